// File: rtl/buffered_uart.sv
// Bus-mapped UART with TX/RX FIFOs, W1C error flags, flush and internal loopback.
// Optional parity generation/checking when BUFFERED_UART_PARITY_EN is defined.

module buffered_uart_fifo #(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level
);
    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

module buffered_uart #(
    parameter int unsigned DATA_BITS       = 8,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4,
    parameter int unsigned OVS             = 16,
    parameter logic [15:0] DIV_RESET       = 16'd53
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        txd_o,
    input  logic        rxd_i,
    input  logic        sel_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic        we_i,
    output logic        irq_o
);
    // state    | meaning
    // S_IDLE   | line idle / waiting for a character or start edge
    // S_START  | start bit
    // S_DATA   | DATA_BITS data bits, LSB first
    // S_PARITY | parity bit (only reachable with parity enabled)
    // S_STOP   | stop bit
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_t;

    localparam int unsigned LW = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned OW = $clog2(OVS);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [OW-1:0] OVS_LAST  = OW'(OVS - 1);
    localparam logic [OW-1:0] HALF_LAST = OW'(OVS / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic wr_en, rd_en, wr_data, wr_status, wr_div, wr_ctrl, rd_pop;
    logic tx_flush, rx_flush;
    logic [15:0] div_q, presc;
    logic tick;
    logic loopback, par_en, par_odd;
    logic fe, ovr, pe;

    assign wr_en     = sel_i && we_i;
    assign rd_en     = sel_i && !we_i;
    assign wr_data   = wr_en && (addr_i == 2'd0);
    assign wr_status = wr_en && (addr_i == 2'd1);
    assign wr_div    = wr_en && (addr_i == 2'd2);
    assign wr_ctrl   = wr_en && (addr_i == 2'd3);
    assign tx_flush  = wr_ctrl && data_i[1];
    assign rx_flush  = wr_ctrl && data_i[0];

    logic unused_bits;
    assign unused_bits = ^data_i[31:16];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            div_q    <= DIV_RESET;
            presc    <= '0;
            loopback <= 1'b0;
        end else begin
            if (wr_div) div_q <= data_i[15:0];
            if (wr_div || tick) presc <= '0;
            else                presc <= presc + 1'b1;
            if (wr_ctrl) loopback <= data_i[2];
        end
    end
    assign tick = (presc == div_q);

`ifdef BUFFERED_UART_PARITY_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            par_en  <= 1'b0;
            par_odd <= 1'b0;
        end else if (wr_ctrl) begin
            par_en  <= data_i[3];
            par_odd <= data_i[4];
        end
    end
`else
    assign par_en  = 1'b0;
    assign par_odd = 1'b0;
`endif

    // ---------------- TX ----------------
    logic [DATA_BITS-1:0] tx_head, tx_shift;
    logic                 tx_empty, tx_full, tx_pop, tx_par, tx_bit_end;
    logic [LW-1:0]        tx_level_unused;
    logic [OW-1:0]        tx_cnt;
    logic [BW-1:0]        tx_bits;
    uart_state_t          tx_state, tx_state_nxt;

    buffered_uart_fifo #(.W(DATA_BITS), .AW(FIFO_DEPTH_LOG2)) u_tx_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .flush(tx_flush), .push(wr_data), .pop(tx_pop),
        .wdata(data_i[DATA_BITS-1:0]), .rdata(tx_head), .empty(tx_empty),
        .full(tx_full), .level(tx_level_unused)
    );

    assign tx_bit_end = tick && (tx_cnt == '0);

    always_comb begin
        tx_state_nxt = tx_state;
        tx_pop       = 1'b0;
        case (tx_state)
            S_IDLE:   if (tick && !tx_empty) begin
                          tx_pop       = 1'b1;
                          tx_state_nxt = S_START;
                      end
            S_START:  if (tx_bit_end) tx_state_nxt = S_DATA;
            S_DATA:   if (tx_bit_end && (tx_bits == '0)) tx_state_nxt = par_en ? S_PARITY : S_STOP;
            S_PARITY: if (tx_bit_end) tx_state_nxt = S_STOP;
            S_STOP:   if (tx_bit_end) begin
                          if (!tx_empty) begin
                              tx_pop       = 1'b1;
                              tx_state_nxt = S_START;
                          end else begin
                              tx_state_nxt = S_IDLE;
                          end
                      end
            default:  tx_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tx_state <= S_IDLE;
            tx_shift <= '0;
            tx_cnt   <= '0;
            tx_bits  <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            if (tx_pop) begin
                tx_shift <= tx_head;
                tx_cnt   <= OVS_LAST;
                tx_bits  <= BIT_LAST;
                tx_par   <= (^tx_head) ^ par_odd;
            end else if (tick && (tx_state != S_IDLE)) begin
                if (tx_cnt == '0) begin
                    tx_cnt <= OVS_LAST;
                    if (tx_state == S_DATA) begin
                        tx_shift <= tx_shift >> 1;
                        tx_bits  <= tx_bits - 1'b1;
                    end
                end else begin
                    tx_cnt <= tx_cnt - 1'b1;
                end
            end
        end
    end

    // decoded from state flops so reset forces the line high without a clock
    always_comb begin
        case (tx_state)
            S_START:  txd_o = 1'b0;
            S_DATA:   txd_o = tx_shift[0];
            S_PARITY: txd_o = tx_par;
            default:  txd_o = 1'b1;
        endcase
    end

    // ---------------- RX ----------------
    logic                 rx_meta, rx_sync, rx_in, rx_sample, rx_done, rx_push;
    logic [DATA_BITS-1:0] rx_shift, rx_head;
    logic                 rx_empty, rx_full;
    logic [LW-1:0]        rx_level;
    logic [OW-1:0]        rx_cnt;
    logic [BW-1:0]        rx_bits;
    uart_state_t          rx_state, rx_state_nxt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rxd_i;
            rx_sync <= rx_meta;
        end
    end

    assign rx_in     = loopback ? txd_o : rx_sync;
    assign rx_sample = tick && (rx_cnt == '0);
    assign rd_pop    = rd_en && (addr_i == 2'd0) && !rx_empty;
    assign rx_push   = rx_done;

    buffered_uart_fifo #(.W(DATA_BITS), .AW(FIFO_DEPTH_LOG2)) u_rx_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .flush(rx_flush), .push(rx_push), .pop(rd_pop),
        .wdata(rx_shift), .rdata(rx_head), .empty(rx_empty),
        .full(rx_full), .level(rx_level)
    );

    always_comb begin
        rx_state_nxt = rx_state;
        rx_done      = 1'b0;
        case (rx_state)
            S_IDLE:   if (tick && !rx_in) rx_state_nxt = S_START;
            S_START:  if (rx_sample) rx_state_nxt = rx_in ? S_IDLE : S_DATA;
            S_DATA:   if (rx_sample && (rx_bits == '0)) rx_state_nxt = par_en ? S_PARITY : S_STOP;
            S_PARITY: if (rx_sample) rx_state_nxt = S_STOP;
            S_STOP:   if (rx_sample) begin
                          rx_done      = 1'b1;
                          rx_state_nxt = S_IDLE;
                      end
            default:  rx_state_nxt = S_IDLE;
        endcase
        if (rx_flush) begin
            rx_state_nxt = S_IDLE;
            rx_done      = 1'b0;
        end
    end

    // counter parks at the half-bit value while idle so START samples mid-bit
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_state <= S_IDLE;
            rx_shift <= '0;
            rx_cnt   <= '0;
            rx_bits  <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            if (rx_state == S_IDLE) begin
                rx_cnt  <= HALF_LAST;
                rx_bits <= BIT_LAST;
            end else if (tick) begin
                if (rx_cnt == '0) begin
                    rx_cnt <= OVS_LAST;
                    if (rx_state == S_DATA) begin
                        rx_shift <= {rx_in, rx_shift[DATA_BITS-1:1]};
                        rx_bits  <= rx_bits - 1'b1;
                    end
                end else begin
                    rx_cnt <= rx_cnt - 1'b1;
                end
            end
        end
    end

    // ---------------- flags and bus ----------------
    logic fe_set, ovr_set;
    assign fe_set  = rx_done && !rx_in;
    assign ovr_set = rx_done && rx_full && !rd_pop;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fe  <= 1'b0;
            ovr <= 1'b0;
        end else begin
            fe  <= (fe  && !(wr_status && data_i[2])) || fe_set;
            ovr <= (ovr && !(wr_status && data_i[3])) || ovr_set;
        end
    end

`ifdef BUFFERED_UART_PARITY_EN
    logic pe_set;
    assign pe_set = (rx_state == S_PARITY) && rx_sample && !rx_flush &&
                    (rx_in != ((^rx_shift) ^ par_odd));
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) pe <= 1'b0;
        else        pe <= (pe && !(wr_status && data_i[6])) || pe_set;
    end
`else
    assign pe = 1'b0;
`endif

    logic [31:0] status_word, ctrl_word;
    always_comb begin
        status_word       = '0;
        status_word[0]    = !tx_empty || (tx_state != S_IDLE);
        status_word[1]    = !rx_empty;
        status_word[2]    = fe;
        status_word[3]    = ovr;
        status_word[4]    = tx_full;
        status_word[5]    = rx_full;
        status_word[6]    = pe;
        status_word[15:8] = 8'(rx_level);
    end
    assign ctrl_word = {27'b0, par_odd, par_en, loopback, 2'b00};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_o <= '0;
        end else if (rd_en) begin
            case (addr_i)
                2'd0:    data_o <= rx_empty ? 32'd0 : 32'(rx_head);
                2'd1:    data_o <= status_word;
                2'd2:    data_o <= {16'b0, div_q};
                default: data_o <= ctrl_word;
            endcase
        end
    end

    assign irq_o = !rx_empty || fe || ovr || pe;
endmodule

// File: tb/tb_buffered_uart.sv
// Directed bench for buffered_uart (default parameters, parity macro undefined).
module tb_buffered_uart;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        txd_o;
    logic        rxd_i = 1'b1;
    logic        sel_i = 1'b0;
    logic [1:0]  addr_i = 2'd0;
    logic [31:0] data_i = 32'd0;
    logic [31:0] data_o;
    logic        we_i = 1'b0;
    logic        irq_o;

    always #5 clk_i = ~clk_i;

    buffered_uart dut (
        .clk_i(clk_i), .rst_i(rst_i), .txd_o(txd_o), .rxd_i(rxd_i),
        .sel_i(sel_i), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
        .we_i(we_i), .irq_o(irq_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0]  addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk_i);
        sel_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d;
        @(negedge clk_i);
        sel_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk_i);
        sel_i = 1'b1; we_i = 1'b0; addr_i = a;
        @(negedge clk_i);
        sel_i = 1'b0;
        d = data_o;
    endtask

    task automatic wait_tx_start(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (txd_o == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop_bit);
        rxd_i = 1'b0;
        repeat (16) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            rxd_i = d[i];
            repeat (16) @(negedge clk_i);
        end
        rxd_i = stop_bit;
        repeat (16) @(negedge clk_i);
        rxd_i = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        ok;
        logic [7:0]  a5;
        int          lowcnt;

        vecs[0]  = '{2'd2, 1'b0, 32'h0,         32'h0000_0035, "rst_div"};
        vecs[1]  = '{2'd1, 1'b0, 32'h0,         32'h0000_0000, "rst_status"};
        vecs[2]  = '{2'd3, 1'b0, 32'h0,         32'h0000_0000, "rst_ctrl"};
        vecs[3]  = '{2'd0, 1'b0, 32'h0,         32'h0000_0000, "rst_data_empty"};
        vecs[4]  = '{2'd2, 1'b1, 32'hABCD_1234, 32'h0,         "wr_div"};
        vecs[5]  = '{2'd2, 1'b0, 32'h0,         32'h0000_1234, "div_rw"};
        vecs[6]  = '{2'd3, 1'b1, 32'h0000_0004, 32'h0,         "wr_ctrl_lb"};
        vecs[7]  = '{2'd3, 1'b0, 32'h0,         32'h0000_0004, "ctrl_loopback"};
        vecs[8]  = '{2'd3, 1'b1, 32'h0000_001B, 32'h0,         "wr_ctrl_flush"};
        vecs[9]  = '{2'd3, 1'b0, 32'h0,         32'h0000_0000, "ctrl_flush_bits"};
        vecs[10] = '{2'd1, 1'b1, 32'h0000_00FF, 32'h0,         "wr_status_w1c"};
        vecs[11] = '{2'd1, 1'b0, 32'h0,         32'h0000_0000, "status_idle"};
        vecs[12] = '{2'd2, 1'b1, 32'h0000_0000, 32'h0,         "wr_div0"};
        vecs[13] = '{2'd2, 1'b0, 32'h0,         32'h0000_0000, "div_zero"};

        // reset state
        repeat (3) @(negedge clk_i);
        check("rst_txd", {31'b0, txd_o}, 32'd1);
        check("rst_irq", {31'b0, irq_o}, 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_data_o", data_o, 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].we) begin
                bus_write(vecs[i].addr, vecs[i].wdata);
            end else begin
                bus_read(vecs[i].addr, rd);
                check(vecs[i].name, rd, vecs[i].exp);
            end
        end

        // TX frame 0xA5 at DIV=0: 16 clocks per bit
        a5 = 8'hA5;
        bus_write(2'd0, 32'h0000_00A5);
        wait_tx_start(ok);
        check("tx_a5_start_seen", {31'b0, ok}, 32'd1);
        repeat (8) @(negedge clk_i);
        check("tx_a5_start_bit", {31'b0, txd_o}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            repeat (16) @(negedge clk_i);
            check($sformatf("tx_a5_bit%0d", k), {31'b0, txd_o}, {31'b0, a5[k]});
        end
        repeat (16) @(negedge clk_i);
        check("tx_a5_stop", {31'b0, txd_o}, 32'd1);
        repeat (7) @(negedge clk_i);
        sel_i = 1'b1; we_i = 1'b0; addr_i = 2'd1;
        @(negedge clk_i);
        check("tx_busy_last_stop", {31'b0, data_o[0]}, 32'd1);
        @(negedge clk_i);
        check("tx_busy_dropped", {31'b0, data_o[0]}, 32'd0);
        sel_i = 1'b0;

        // loopback, three back-to-back frames
        bus_write(2'd3, 32'h0000_0004);
        bus_write(2'd0, 32'h0000_0000);
        wait_tx_start(ok);
        check("lb_start_seen", {31'b0, ok}, 32'd1);
        bus_write(2'd0, 32'h0000_007F);
        bus_write(2'd0, 32'h0000_00FF);
        repeat (155) @(negedge clk_i);
        check("lb_f1_stop", {31'b0, txd_o}, 32'd1);
        @(negedge clk_i);
        check("lb_f2_no_gap", {31'b0, txd_o}, 32'd0);
        repeat (159) @(negedge clk_i);
        check("lb_f2_stop", {31'b0, txd_o}, 32'd1);
        @(negedge clk_i);
        check("lb_f3_no_gap", {31'b0, txd_o}, 32'd0);
        repeat (200) @(negedge clk_i);
        bus_read(2'd1, rd);
        check("lb_status_level3", rd, 32'h0000_0302);
        check("lb_irq", {31'b0, irq_o}, 32'd1);
        bus_read(2'd0, rd); check("lb_rx0", rd, 32'h00);
        bus_read(2'd0, rd); check("lb_rx1", rd, 32'h7F);
        bus_read(2'd0, rd); check("lb_rx2", rd, 32'hFF);
        bus_read(2'd0, rd); check("lb_rx_empty", rd, 32'h00);
        bus_read(2'd1, rd); check("lb_status_empty", rd, 32'h0000_0000);
        check("lb_irq_clear", {31'b0, irq_o}, 32'd0);

        // overrun: 17 characters into a 16-deep RX FIFO
        for (int i = 0; i < 17; i++) bus_write(2'd0, 32'h10 + i);
        repeat (2900) @(negedge clk_i);
        bus_read(2'd1, rd);
        check("ovr_status", rd, 32'h0000_102A);
        check("ovr_irq", {31'b0, irq_o}, 32'd1);
        bus_write(2'd1, 32'h0000_0008);
        bus_read(2'd1, rd);
        check("ovr_w1c", rd, 32'h0000_1022);
        for (int i = 0; i < 16; i++) begin
            bus_read(2'd0, rd);
            check($sformatf("ovr_fifo_data%0d", i), rd, 32'h10 + i);
        end
        bus_read(2'd1, rd);
        check("ovr_drained", rd, 32'h0000_0000);

        // external line: short glitch, then a frame with a bad stop bit
        bus_write(2'd3, 32'h0000_0000);
        rxd_i = 1'b0;
        repeat (7) @(negedge clk_i);
        rxd_i = 1'b1;
        repeat (40) @(negedge clk_i);
        bus_read(2'd1, rd);
        check("glitch_ignored", rd, 32'h0000_0000);
        drive_frame(8'h55, 1'b0);
        repeat (40) @(negedge clk_i);
        bus_read(2'd1, rd);
        check("fe_status", rd, 32'h0000_0106);
        bus_read(2'd0, rd);
        check("fe_char", rd, 32'h55);
        bus_write(2'd1, 32'h0000_0004);
        bus_read(2'd1, rd);
        check("fe_w1c", rd, 32'h0000_0000);
        check("fe_irq_clear", {31'b0, irq_o}, 32'd0);

        // prescaler: DIV=1 doubles bit time; start bit of 0x01 is 32 clocks
        bus_write(2'd2, 32'h0000_0001);
        bus_write(2'd0, 32'h0000_0001);
        wait_tx_start(ok);
        check("div1_start_seen", {31'b0, ok}, 32'd1);
        lowcnt = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (txd_o != 1'b0) break;
            lowcnt++;
        end
        check("div1_start_len", lowcnt, 32'd32);
        repeat (400) @(negedge clk_i);

        // asynchronous reset in the middle of a frame
        bus_write(2'd2, 32'h0000_0000);
        bus_write(2'd3, 32'h0000_0004);
        bus_write(2'd0, 32'h0000_003C);
        repeat (200) @(negedge clk_i);
        bus_write(2'd0, 32'h0000_0011);
        bus_write(2'd0, 32'h0000_0022);
        bus_write(2'd0, 32'h0000_0033);
        wait_tx_start(ok);
        check("rst_mid_start_seen", {31'b0, ok}, 32'd1);
        repeat (4) @(negedge clk_i);
        check("rst_mid_pre_txd", {31'b0, txd_o}, 32'd0);
        check("rst_mid_pre_irq", {31'b0, irq_o}, 32'd1);
        #2 rst_i = 1'b0;
        #1 check("rst_mid_txd_async", {31'b0, txd_o}, 32'd1);
        check("rst_mid_irq", {31'b0, irq_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        bus_read(2'd1, rd);
        check("rst_mid_status", rd, 32'h0000_0000);
        bus_read(2'd2, rd);
        check("rst_mid_div", rd, 32'h0000_0035);
        bus_read(2'd3, rd);
        check("rst_mid_ctrl", rd, 32'h0000_0000);
        check("rst_mid_txd_idle", {31'b0, txd_o}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/buffered_uart.md
Name: buffered_uart

Overview:
- Second-generation bus-mapped UART for the picorv32 SoC peripheral bus.
- Replaces the single-byte transmit and receive registers with parametrised TX and RX FIFOs.
- Character width and oversampling ratio are parametrised; sticky error flags are write-1-to-clear.
- Adds overrun detection, FIFO flush and internal loopback; sits on the same sel/we/addr word bus as the other simple peripherals.

Parameters:
- DATA_BITS, 8: character width, legal 5..8; LSB first, 1 stop bit.
- FIFO_DEPTH_LOG2, 4: each FIFO holds 2**FIFO_DEPTH_LOG2 entries (default 16).
- OVS, 16: baud ticks per bit; even, legal 4..16.
- DIV_RESET, 16'd53: reset value of the DIV register.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-low
- txd_o  out  1  serial out, idles high
- rxd_i  in  1  serial in, asynchronous to clk_i
- sel_i  in  1  bus select, one access per cycle it is high
- addr_i  in  2  register index
- data_i  in  32  write data
- data_o  out  32  registered read data
- we_i  in  1  1 = write, 0 = read
- irq_o  out  1  level interrupt: rx_avail OR fe OR ovr

Behaviour:
- Reset values: txd_o=1, data_o=0, irq_o=0, both FIFOs empty, fe=ovr=0, CTRL=0, DIV=DIV_RESET.
- Register map, write side:
  - 0 DATA: push data_i[DATA_BITS-1:0] into the TX FIFO. If the TX FIFO is full, the write is dropped and no flag is set.
  - 1 STATUS: W1C; data_i[2] clears fe, data_i[3] clears ovr.
  - 2 DIV: DIV <= data_i[15:0].
  - 3 CTRL: bit0 rx_flush and bit1 tx_flush are self-clearing, acting 1 cycle; bit2 loopback is stored.
- Register map, read side:
  - 0 DATA: returns the RX FIFO head, zero-extended, then pops it. If the RX FIFO is empty, returns 0 and nothing is popped.
  - 1 STATUS:
    - bit0 tx_busy = TX FIFO not empty OR shifter active
    - bit1 rx_avail
    - bit2 fe
    - bit3 ovr
    - bit4 tx_full
    - bit5 rx_full
    - bits[15:8] RX level
    - all other bits 0
  - 2 DIV: returns {16'b0, DIV}.
  - 3 CTRL: returns {29'b0, loopback, 2'b0}.
- Read latency: data_o is updated on the clock edge after sel_i && !we_i and holds its value otherwise.
- Baud tick:
  - A 16-bit prescaler counts 0..DIV and pulses tick for 1 cycle when count==DIV, then restarts at 0.
  - Bit time = (DIV+1)*OVS clocks.
  - A write to DIV restarts the prescaler at 0.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: when the FIFO is not empty, pop the head into the shifter and move to START at the next tick.
  - Each of START, DATA and STOP holds txd_o for exactly OVS ticks.
  - DATA shifts out DATA_BITS bits, LSB first.
  - From STOP, go straight to START when the FIFO is non-empty, giving back-to-back frames with no idle gap.
- RX input path:
  - rxd_i passes through a 2-flop synchroniser.
  - With loopback=1 the receiver input is txd_o instead, and txd_o is still driven.
- RX FSM: IDLE -> START -> DATA -> STOP.
  - IDLE: a sampled 0 on any tick enters START.
  - START: at tick OVS/2, a sample of 1 is a glitch and returns to IDLE; a sample of 0 proceeds.
  - DATA: sample every OVS ticks thereafter (bit centre).
  - STOP: sample the stop bit. If it is 0, set fe; the character is still delivered.
  - Delivery: push into the RX FIFO; if the RX FIFO is full, drop the character and set ovr.
- Simultaneous events:
  - Same-cycle push and pop on one FIFO are both performed; the level is unchanged.
  - Same-cycle RX frame completion and W1C of fe/ovr: the set wins.
- Flush:
  - tx_flush empties the TX FIFO only; a character already in the shifter completes.
  - rx_flush empties the RX FIFO and aborts an in-progress receive to IDLE.
- Reset mid-frame: reset is asynchronous; txd_o returns to 1 immediately and all FIFO contents are lost.
- FIFO pointers are FIFO_DEPTH_LOG2+1 bits wide. Full = MSBs differ and the rest are equal; level = wr_ptr - rd_ptr, modulo wrap.

Optional Feature:
- Macro: BUFFERED_UART_PARITY_EN.
- When defined:
  - CTRL bit3 = parity enable, CTRL bit4 = odd parity (0 = even); both readable and writable.
  - When enabled, TX inserts a parity bit between data and stop.
  - RX checks the parity bit; a mismatch sets sticky STATUS bit6 pe, which is W1C via data_i[6] and ORed into irq_o. The character is still delivered.
- When undefined: CTRL bits 3/4 and STATUS bit6 read 0, writes to them are ignored, and frames carry no parity bit.

Test Plan:
- Reset, then read every register -> DIV=0x35, STATUS=0, CTRL=0; txd_o=1.
- DIV=0, OVS=16, write DATA 0xA5 -> txd_o shows start 0, then 1,0,1,0,0,1,0,1, then stop 1; each bit 16 clocks; STATUS.tx_busy drops on the cycle after the stop bit ends.
- Loopback=1, write 0x00,0x7F,0xFF back-to-back -> no idle gap between frames; STATUS[15:8]=3; three DATA reads return 0x00,0x7F,0xFF; a fourth read returns 0 and the level stays 0.
- With no reads, loop back 17 characters at depth 16 -> rx_full=1, ovr=1, irq_o=1; write STATUS 0x8 -> ovr=0; the FIFO still holds the first 16 characters.
- Drive rxd_i low for OVS/2-1 ticks, then high -> no character and no fe. Send frame 0x55 with stop bit 0 -> 0x55 received, fe=1.
- Assert rst_i mid-TX frame -> txd_o=1 asynchronously; after release both FIFOs are empty and DIV=0x35.
